button_press_decoder: RTL and testbench
=======================================

# button_press_decoder

Downstream of the per-button debouncer; turns one clean, active-high button level into timed user events for the alarm-clock control logic. It emits a single-cycle pulse on press, release, long-press and auto-repeat, so the time-set and alarm-set logic can step digits on a tap and scroll them while the button is held. Hold and repeat timing use an external tick enable, so the same block serves every button.

## Interface
- LONG_PRESS_TICKS, 1000: ticks of continuous hold before o_Long fires; must be ≥ 1.
- REPEAT_TICKS, 200: ticks between o_Repeat pulses after o_Long; must be ≥ 1.
- CNT_WIDTH, 16: hold counter width; must hold max(LONG_PRESS_TICKS, REPEAT_TICKS) − 1.
- i_Clk  in  1  system clock, 100 MHz; one clock; all logic on its rising edge.
- i_Reset  in  1  synchronous reset, active-high.
- i_Tick  in  1  one-cycle time-base enable (1 kHz strobe in the top level).
- i_Signal  in  1  debounced button level, active-high, synchronous to i_Clk.
- o_Press  out  1  one-cycle pulse on press.
- o_Release  out  1  one-cycle pulse on release.
- o_Long  out  1  one-cycle pulse when the hold reaches LONG_PRESS_TICKS.
- o_Repeat  out  1  one-cycle pulse every REPEAT_TICKS while held in long state.
- o_Held  out  1  level: high while the state is not S_IDLE.

## Operation
- Internal r_Prev holds the previous i_Signal sample. Rise is i_Signal=1 and r_Prev=0.
- Three-state FSM driven by one hold counter r_Cnt:
  - S_IDLE: on rise, pulse o_Press, clear r_Cnt and go to S_SHORT. Otherwise stay.
  - S_SHORT: if i_Signal=0, pulse o_Release and go to S_IDLE. Else, on i_Tick:
    - if r_Cnt = LONG_PRESS_TICKS−1, pulse o_Long, clear r_Cnt and go to S_LONG;
    - otherwise increment r_Cnt.
  - S_LONG: if i_Signal=0, pulse o_Release and go to S_IDLE. Else, on i_Tick:
    - if r_Cnt = REPEAT_TICKS−1, pulse o_Repeat and clear r_Cnt;
    - otherwise increment r_Cnt.
- Release takes priority over a coincident threshold tick: o_Release only, no o_Long or o_Repeat.
- i_Tick is ignored in S_IDLE. r_Cnt never exceeds its threshold, so no wrap is possible.
- At most one pulse output is high in any cycle.
- o_Press and o_Release always come in pairs within a press, except across reset.

## Timing
- All outputs are registered.
- Reset values: o_Press, o_Release, o_Long, o_Repeat and o_Held = 0; state = S_IDLE; r_Cnt = 0; r_Prev = 1.
  - Because r_Prev resets to 1, a button held through reset produces no o_Press. A release followed by a new press is required.
- Latency:
  - If i_Signal is first sampled 1 at edge k, o_Press and o_Held rise after edge k.
  - o_Press lasts exactly one cycle.
- Release: if i_Signal is first sampled 0 at edge k, o_Release pulses after edge k. o_Held falls after the same edge.
- Long press: o_Long pulses after the edge that samples the LONG_PRESS_TICKS-th i_Tick since the press.
  - A tick on the press-detect edge itself is not counted.
- Repeat: o_Repeat pulses every REPEAT_TICKS ticks after o_Long.
- Reset mid-press: all outputs are 0 after the reset edge. No o_Release is generated. The FSM returns to S_IDLE.
- A rise in the cycle immediately after a release is a valid new press.

## Structure
- Shared package alarm_clock_pkg holds:
  - state encodings S_IDLE=2'd0, S_SHORT=2'd1, S_LONG=2'd2;
  - default tick constants for the 1 kHz time base (LONG_PRESS_TICKS, REPEAT_TICKS).
- One natural sub-module, edge_detect: registered rise/fall detector with reset value as a parameter. It is reused by the alarm-enable switch path.
- The FSM and counter stay in the top module.

## Test plan
Bench parameters: LONG_PRESS_TICKS=5, REPEAT_TICKS=3; i_Tick once every 10 clocks.
- Short tap: hold 20 clocks (2 ticks) → exactly one o_Press and one o_Release; no o_Long; o_Held high for 20 cycles.
- Long hold: hold 120 clocks → o_Press, then o_Long after the 5th tick, then o_Repeat after ticks 8 and 11, then o_Release on drop.
- Coincident events: release sampled on the same edge as the 5th tick → o_Release only; no o_Long.
- Held through reset: i_Signal=1 before and during the reset pulse → no o_Press until i_Signal goes low and then high again; that new press gives o_Press after 1 cycle.
- Reset mid-operation: assert i_Reset while in S_LONG → all outputs 0 the next cycle; no o_Release; the next fresh press behaves normally.
- Back-to-back taps: release for 1 clock between two presses → two o_Press and two o_Release pulses; the pulse outputs are never high together.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm-clock control path: button-decoder state
// encodings and default hold/repeat timing for the 1 kHz time base.
package alarm_clock_pkg;

  // Button decoder states; S_IDLE must stay 0 so reset and "not held" agree.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHORT = 2'd1,
    S_LONG  = 2'd2
  } btn_state_t;

  // 1 s to a long press and 200 ms between repeats at a 1 kHz tick.
  localparam int DEFAULT_LONG_PRESS_TICKS = 1000;
  localparam int DEFAULT_REPEAT_TICKS     = 200;
  localparam int DEFAULT_CNT_WIDTH        = 16;

endpackage

// File: rtl/button_press_decoder_if.sv
// Bundle of the per-button control and event signals so a button, its
// decoder and the consuming control logic can be wired as one connection.
interface button_press_decoder_if;

  logic i_Tick;
  logic i_Signal;
  logic o_Press;
  logic o_Release;
  logic o_Long;
  logic o_Repeat;
  logic o_Held;

  // The side that owns the button level and time base.
  modport master (
    output i_Tick,
    output i_Signal,
    input  o_Press,
    input  o_Release,
    input  o_Long,
    input  o_Repeat,
    input  o_Held
  );

  // The decoder side.
  modport slave (
    input  i_Tick,
    input  i_Signal,
    output o_Press,
    output o_Release,
    output o_Long,
    output o_Repeat,
    output o_Held
  );

endinterface

// File: rtl/button_press_decoder_edge_detect.sv
// Rise/fall detector built on one registered copy of the input level. The
// reset value of that register is a parameter so a level that is already
// high out of reset can be treated as "no edge" (buttons) or as a real edge
// (switch paths that want one).
module edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev_d;
  logic prev_q;

  // Next value of the history register is simply the current level.
  always_comb begin
    prev_d = sig;
  end

  // History register holding last cycle's level.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = sig & ~prev_q;
  assign fall = ~sig & prev_q;

endmodule

// File: rtl/button_press_decoder.sv
// Turns one debounced button level into single-cycle press, release,
// long-press and auto-repeat events plus a "held" level. Hold timing counts
// an external tick enable so one design serves every button.
module button_press_decoder
  import alarm_clock_pkg::*;
#(
  parameter int LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS,
  parameter int REPEAT_TICKS     = DEFAULT_REPEAT_TICKS,
  parameter int CNT_WIDTH        = DEFAULT_CNT_WIDTH
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Tick,
  input  logic i_Signal,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long,
  output logic o_Repeat,
  output logic o_Held
);

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_PRESS_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);

  btn_state_t           state_d, state_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 press_d, press_q;
  logic                 rel_d, rel_q;
  logic                 long_d, long_q;
  logic                 rpt_d, rpt_q;
  logic                 held_d, held_q;
  logic                 sig_rise;
  logic                 sig_fall;

  // History resets high so a button held through reset is not a press.
  // While in S_SHORT/S_LONG the level was high last cycle, so a fall there
  // is exactly "the level is now low".
  edge_detect #(
    .RESET_VAL (1'b1)
  ) u_edge (
    .clk  (i_Clk),
    .rst  (i_Reset),
    .sig  (i_Signal),
    .rise (sig_rise),
    .fall (sig_fall)
  );

  // Next-state, hold counter and event decode; release wins over any tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sig_rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = S_SHORT;
        end
      end
      S_SHORT: begin
        if (sig_fall) begin
          rel_d   = 1'b1;
          state_d = S_IDLE;
        end else if (i_Tick) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_LONG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LONG: begin
        if (sig_fall) begin
          rel_d   = 1'b1;
          state_d = S_IDLE;
        end else if (i_Tick) begin
          if (cnt_q == REPEAT_LAST) begin
            rpt_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != S_IDLE);
  end

  // State, counter and registered event outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
    end
  end

  assign o_Press   = press_q;
  assign o_Release = rel_q;
  assign o_Long    = long_q;
  assign o_Repeat  = rpt_q;
  assign o_Held    = held_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with short thresholds
// (long press after 5 ticks, repeat every 3) and a tick every 10 clocks.
module tb_button_press_decoder;

  logic clk;
  logic reset;

  button_press_decoder_if bif ();

  button_press_decoder #(
    .LONG_PRESS_TICKS (5),
    .REPEAT_TICKS     (3),
    .CNT_WIDTH        (16)
  ) dut (
    .i_Clk     (clk),
    .i_Reset   (reset),
    .i_Tick    (bif.i_Tick),
    .i_Signal  (bif.i_Signal),
    .o_Press   (bif.o_Press),
    .o_Release (bif.o_Release),
    .o_Long    (bif.o_Long),
    .o_Repeat  (bif.o_Repeat),
    .o_Held    (bif.o_Held)
  );

  int errors = 0;
  int checks = 0;

  int tick_phase;
  int cyc;
  int press_cnt, rel_cnt, long_cnt, rpt_cnt, held_cnt;
  int overlap_cnt = 0;
  int long_cyc, first_rpt_cyc, last_rpt_cyc, rel_cyc;

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    cyc           = 0;
    press_cnt     = 0;
    rel_cnt       = 0;
    long_cnt      = 0;
    rpt_cnt       = 0;
    held_cnt      = 0;
    long_cyc      = -1;
    first_rpt_cyc = -1;
    last_rpt_cyc  = -1;
    rel_cyc       = -1;
  endtask

  // Drive one clock of inputs, then sample and tally outputs after the edge.
  task automatic applyStimulus(input logic sig, input logic tick, input logic rst);
    @(negedge clk);
    bif.i_Signal = sig;
    bif.i_Tick   = tick;
    reset        = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (bif.o_Press) press_cnt++;
    if (bif.o_Release) begin
      rel_cnt++;
      rel_cyc = cyc;
    end
    if (bif.o_Long) begin
      long_cnt++;
      long_cyc = cyc;
    end
    if (bif.o_Repeat) begin
      rpt_cnt++;
      if (first_rpt_cyc < 0) first_rpt_cyc = cyc;
      last_rpt_cyc = cyc;
    end
    if (bif.o_Held) held_cnt++;
    if ((int'(bif.o_Press) + int'(bif.o_Release) + int'(bif.o_Long) + int'(bif.o_Repeat)) > 1)
      overlap_cnt++;
  endtask

  // Run n cycles at a fixed level with the periodic tick (every 10th cycle).
  task automatic runCycles(input logic sig, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(sig, (tick_phase == 9), 1'b0);
      tick_phase = (tick_phase + 1) % 10;
    end
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "_press"},   int'(bif.o_Press),   0);
    checkOutput({tag, "_release"}, int'(bif.o_Release), 0);
    checkOutput({tag, "_long"},    int'(bif.o_Long),    0);
    checkOutput({tag, "_repeat"},  int'(bif.o_Repeat),  0);
    checkOutput({tag, "_held"},    int'(bif.o_Held),    0);
  endtask

  initial begin
    bif.i_Signal = 1'b0;
    bif.i_Tick   = 1'b0;
    reset        = 1'b1;
    tick_phase   = 0;
    clearCounts();

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkAllLow("reset");
    runCycles(1'b0, 5);

    // Short tap: 20 clocks held, two ticks.
    clearCounts();
    tick_phase = 0;
    runCycles(1'b1, 1);
    checkOutput("tap_press_latency", int'(bif.o_Press), 1);
    checkOutput("tap_held_rise", int'(bif.o_Held), 1);
    runCycles(1'b1, 1);
    checkOutput("tap_press_one_cycle", int'(bif.o_Press), 0);
    runCycles(1'b1, 18);
    runCycles(1'b0, 1);
    checkOutput("tap_release_now", int'(bif.o_Release), 1);
    checkOutput("tap_held_fall", int'(bif.o_Held), 0);
    runCycles(1'b0, 4);
    checkOutput("tap_press_cnt", press_cnt, 1);
    checkOutput("tap_release_cnt", rel_cnt, 1);
    checkOutput("tap_long_cnt", long_cnt, 0);
    checkOutput("tap_held_cycles", held_cnt, 20);

    // Long hold: 120 clocks, ticks on cycles 10,20,...,120.
    clearCounts();
    tick_phase = 0;
    runCycles(1'b1, 120);
    runCycles(1'b0, 5);
    checkOutput("long_press_cnt", press_cnt, 1);
    checkOutput("long_long_cnt", long_cnt, 1);
    checkOutput("long_long_cycle", long_cyc, 50);
    checkOutput("long_repeat_cnt", rpt_cnt, 2);
    checkOutput("long_first_repeat", first_rpt_cyc, 80);
    checkOutput("long_last_repeat", last_rpt_cyc, 110);
    checkOutput("long_release_cnt", rel_cnt, 1);
    checkOutput("long_release_cycle", rel_cyc, 121);

    // Release sampled on the same edge as the 5th tick.
    clearCounts();
    tick_phase = 0;
    runCycles(1'b1, 49);
    runCycles(1'b0, 5);
    checkOutput("coinc_long_cnt", long_cnt, 0);
    checkOutput("coinc_release_cnt", rel_cnt, 1);
    checkOutput("coinc_release_cycle", rel_cyc, 50);

    // Button held through reset: no press until it is released and re-pressed.
    clearCounts();
    tick_phase = 0;
    runCycles(1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    clearCounts();
    runCycles(1'b1, 10);
    checkOutput("hold_rst_press_cnt", press_cnt, 0);
    checkOutput("hold_rst_held_cnt", held_cnt, 0);
    runCycles(1'b0, 1);
    runCycles(1'b1, 1);
    checkOutput("hold_rst_new_press", int'(bif.o_Press), 1);
    runCycles(1'b1, 3);
    runCycles(1'b0, 3);
    checkOutput("hold_rst_press_total", press_cnt, 1);
    checkOutput("hold_rst_release_total", rel_cnt, 1);

    // Reset while in S_LONG, then a fresh short press.
    clearCounts();
    tick_phase = 0;
    runCycles(1'b1, 60);
    checkOutput("midrst_long_seen", long_cnt, 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkAllLow("midrst");
    clearCounts();
    runCycles(1'b0, 5);
    checkOutput("midrst_no_release", rel_cnt, 0);
    clearCounts();
    tick_phase = 0;
    runCycles(1'b1, 20);
    runCycles(1'b0, 3);
    checkOutput("midrst_fresh_press", press_cnt, 1);
    checkOutput("midrst_fresh_release", rel_cnt, 1);
    checkOutput("midrst_fresh_long", long_cnt, 0);

    // Back-to-back taps with a one-clock gap.
    clearCounts();
    tick_phase = 0;
    runCycles(1'b1, 15);
    runCycles(1'b0, 1);
    runCycles(1'b1, 1);
    checkOutput("b2b_second_press_now", int'(bif.o_Press), 1);
    runCycles(1'b1, 14);
    runCycles(1'b0, 3);
    checkOutput("b2b_press_cnt", press_cnt, 2);
    checkOutput("b2b_release_cnt", rel_cnt, 2);

    // Pulse outputs never coincided anywhere in the run.
    checkOutput("pulse_exclusive", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
